// File: rtl/load_store_unit_pkg.sv
// Shared load/store definitions.
// funct3 access codes and the LSU state encoding.
package LOAD_STORE_FNS;

   typedef enum logic [2:0] {
      BYTE   = 3'b000,
      HALF   = 3'b001,
      WORD   = 3'b010,
      DOUBLE = 3'b011,
      BYTEU  = 3'b100,
      HALFU  = 3'b101,
      WORDU  = 3'b110
   } funct3_t;

   typedef enum logic [1:0] {
      IDLE,
      BEAT1,
      BEAT2,
      RESP
   } lsu_state_t;

   // D and WU only exist on a 64-bit datapath
   function automatic logic f3_legal(
      input logic [2:0] f3,
      input int         width
   );
      case (f3)
         BYTE, HALF, WORD, BYTEU, HALFU: return 1'b1;
         DOUBLE, WORDU:                  return width == 64;
         default:                        return 1'b0;
      endcase
   endfunction

endpackage

// File: rtl/load_store_unit_extend.sv
// Load lane extraction and sign/zero extension.
// The window is {upper word, lower word} so split loads share it.
module load_extend
   import LOAD_STORE_FNS::*;
#(
   parameter int WIDTH = 32
)(
   input  logic [2*WIDTH-1:0]         i_win,
   input  logic [$clog2(WIDTH/8)-1:0] i_off,
   input  logic [2:0]                 i_funct3,
   output logic [WIDTH-1:0]           o_data
);
   localparam int TW = $clog2(WIDTH);

   logic [2*WIDTH-1:0] w_sh;
   logic [WIDTH-1:0]   w_lane;
   logic [TW-1:0]      w_top;
   logic               w_sign;

   // shift the addressed lane down, then extend above its top bit
   always_comb begin
      w_sh   = i_win >> {i_off, 3'b000};
      w_lane = w_sh[WIDTH-1:0];
      case (i_funct3[1:0])
         2'd0:    w_top = TW'(7);
         2'd1:    w_top = TW'(15);
         2'd2:    w_top = TW'(31);
         default: w_top = TW'(WIDTH - 1);
      endcase
      w_sign = w_lane[w_top] & ~i_funct3[2];
      o_data = '0;
      for (int i = 0; i < WIDTH; i++) begin
         o_data[i] = (i <= int'(w_top)) ? w_lane[i] : w_sign;
      end
   end

endmodule

// File: rtl/load_store_unit.sv
// Load/store unit: sized accesses over a req/ack memory port.
// Misaligned accesses fault or split into two beats.
module load_store_unit
   import LOAD_STORE_FNS::*;
#(
   parameter int WIDTH            = 32,
   parameter int ADDR_WIDTH       = 32,
   parameter int SPLIT_MISALIGNED = 0
)(
   input  logic                  clk,
   input  logic                  rst,
   input  logic                  req_valid,
   output logic                  req_ready,
   input  logic                  req_we,
   input  logic [2:0]            req_funct3,
   input  logic [ADDR_WIDTH-1:0] req_addr,
   input  logic [WIDTH-1:0]      req_wdata,
   output logic                  rsp_valid,
   output logic [WIDTH-1:0]      rsp_rdata,
   output logic                  rsp_fault,
   output logic                  mem_req,
   output logic                  mem_we,
   output logic [ADDR_WIDTH-1:0] mem_addr,
   output logic [WIDTH/8-1:0]    mem_be,
   output logic [WIDTH-1:0]      mem_wdata,
   input  logic                  mem_ack,
   input  logic [WIDTH-1:0]      mem_rdata
);
   localparam int NB = WIDTH / 8;
   localparam int OW = $clog2(NB);

   lsu_state_t r_state, w_next;

   logic                  r_we;
   logic [2:0]            r_f3;
   logic [ADDR_WIDTH-1:0] r_addr;
   logic [WIDTH-1:0]      r_wdata;
   logic [WIDTH-1:0]      r_beat1;
   logic                  r_mem_we;
   logic [ADDR_WIDTH-1:0] r_mem_addr;
   logic [NB-1:0]         r_mem_be;
   logic [WIDTH-1:0]      r_mem_wdata;
   logic [WIDTH-1:0]      r_rdata;
   logic                  r_fault;

   logic                  w_idle;
   logic                  w_we;
   logic [2:0]            w_f3;
   logic [ADDR_WIDTH-1:0] w_addr;
   logic [WIDTH-1:0]      w_wdata;
   logic [OW-1:0]         w_off;
   logic [3:0]            w_nb;
   logic                  w_spill;
   logic                  w_mis;
   logic                  w_fault;
   logic [ADDR_WIDTH-1:0] w_base;
   logic [ADDR_WIDTH-1:0] w_next_addr;
   logic [NB-1:0]         w_bmask;
   logic [WIDTH-1:0]      w_wdm;
   logic [2*NB-1:0]       w_be2;
   logic [2*WIDTH-1:0]    w_wd2;
   logic [2*WIDTH-1:0]    w_win;
   logic [WIDTH-1:0]      w_ld;

   // one shifter: live request in IDLE, latched request afterwards
   always_comb begin
      w_idle      = (r_state == IDLE);
      w_we        = w_idle ? req_we     : r_we;
      w_f3        = w_idle ? req_funct3 : r_f3;
      w_addr      = w_idle ? req_addr   : r_addr;
      w_wdata     = w_idle ? req_wdata  : r_wdata;
      w_off       = w_addr[OW-1:0];
      w_nb        = 4'd1 << w_f3[1:0];
      w_spill     = (4'(w_off) + w_nb) > 4'(NB);
      w_mis       = (4'(w_off) & (w_nb - 4'd1)) != 4'd0;
      w_fault     = !f3_legal(w_f3, WIDTH)
                  || (w_mis && SPLIT_MISALIGNED == 0);
      w_base      = {w_addr[ADDR_WIDTH-1:OW], {OW{1'b0}}};
      w_next_addr = w_base + ADDR_WIDTH'(NB);
      w_bmask     = '0;
      w_wdm       = '0;
      for (int i = 0; i < NB; i++) begin
         w_bmask[i]     = (i < int'(w_nb));
         w_wdm[i*8 +: 8] = w_bmask[i] ? w_wdata[i*8 +: 8] : 8'h00;
      end
      w_be2 = {{NB{1'b0}}, w_bmask} << w_off;
      w_wd2 = {{WIDTH{1'b0}}, w_wdm} << {w_off, 3'b000};
      w_win = (r_state == BEAT2) ? {mem_rdata, r_beat1}
                                 : {{WIDTH{1'b0}}, mem_rdata};
   end

   load_extend #(
      .WIDTH (WIDTH)
   ) u_ext (
      .i_win    (w_win),
      .i_off    (r_addr[OW-1:0]),
      .i_funct3 (r_f3),
      .o_data   (w_ld)
   );

   // state register
   always_ff @(posedge clk or negedge rst) begin
      if (!rst) r_state <= IDLE;
      else      r_state <= w_next;
   end

   // next state and handshake strobes
   always_comb begin
      w_next    = r_state;
      req_ready = 1'b0;
      mem_req   = 1'b0;
      rsp_valid = 1'b0;
      unique case (r_state)
         IDLE: begin
            req_ready = 1'b1;
            if (req_valid) w_next = w_fault ? RESP : BEAT1;
         end
         BEAT1: begin
            mem_req = 1'b1;
            if (mem_ack) w_next = w_spill ? BEAT2 : RESP;
         end
         BEAT2: begin
            mem_req = 1'b1;
            if (mem_ack) w_next = RESP;
         end
         RESP: begin
            rsp_valid = 1'b1;
            w_next    = IDLE;
         end
      endcase
   end

   // request latch, memory-side registers and response registers
   always_ff @(posedge clk or negedge rst) begin
      if (!rst) begin
         r_we        <= 1'b0;
         r_f3        <= 3'b000;
         r_addr      <= '0;
         r_wdata     <= '0;
         r_beat1     <= '0;
         r_mem_we    <= 1'b0;
         r_mem_addr  <= '0;
         r_mem_be    <= '0;
         r_mem_wdata <= '0;
         r_rdata     <= '0;
         r_fault     <= 1'b0;
      end else begin
         unique case (r_state)
            IDLE: if (req_valid) begin
               r_we    <= req_we;
               r_f3    <= req_funct3;
               r_addr  <= req_addr;
               r_wdata <= req_wdata;
               if (w_fault) begin
                  r_fault <= 1'b1;
                  r_rdata <= '0;
               end else begin
                  r_mem_we    <= w_we;
                  r_mem_addr  <= w_base;
                  r_mem_be    <= w_be2[NB-1:0];
                  r_mem_wdata <= w_wd2[WIDTH-1:0];
               end
            end
            BEAT1: if (mem_ack) begin
               r_beat1 <= mem_rdata;
               if (w_spill) begin
                  r_mem_addr  <= w_next_addr;
                  r_mem_be    <= w_be2[2*NB-1:NB];
                  r_mem_wdata <= w_wd2[2*WIDTH-1:WIDTH];
               end else begin
                  r_fault <= 1'b0;
                  r_rdata <= r_we ? '0 : w_ld;
               end
            end
            BEAT2: if (mem_ack) begin
               r_fault <= 1'b0;
               r_rdata <= r_we ? '0 : w_ld;
            end
            RESP: begin
               r_fault     <= 1'b0;
               r_rdata     <= '0;
               r_mem_we    <= 1'b0;
               r_mem_addr  <= '0;
               r_mem_be    <= '0;
               r_mem_wdata <= '0;
            end
         endcase
      end
   end

   assign mem_we    = r_mem_we;
   assign mem_addr  = r_mem_addr;
   assign mem_be    = r_mem_be;
   assign mem_wdata = r_mem_wdata;
   assign rsp_rdata = r_rdata;
   assign rsp_fault = r_fault;

endmodule

// File: tb/tb_load_store_unit.sv
// Directed bench for load_store_unit (WIDTH=32).
// u0 faults on misalignment, u1 splits; shared memory model.
module tb_load_store_unit;

   logic        clk = 1'b0;
   logic        rst = 1'b0;
   logic        req_valid [2];
   logic        req_ready [2];
   logic        req_we;
   logic [2:0]  req_funct3;
   logic [31:0] req_addr;
   logic [31:0] req_wdata;
   logic        rsp_valid [2];
   logic [31:0] rsp_rdata [2];
   logic        rsp_fault [2];
   logic        mem_req   [2];
   logic        mem_we    [2];
   logic [31:0] mem_addr  [2];
   logic [3:0]  mem_be    [2];
   logic [31:0] mem_wdata [2];
   logic        mem_ack   [2];
   logic [31:0] mem_rdata [2];

   logic [31:0] mem [0:255];
   int          cyc = 0;
   int          dly = 1;
   int          cnt [2];
   int          nb  [2];
   int          ack_edge [2];
   logic [31:0] b_addr [2][4];
   logic [3:0]  b_be   [2][4];
   logic [31:0] b_wd   [2][4];

   int          n_chk  = 0;
   int          n_pass = 0;
   logic        g_seen;
   logic [31:0] g_rd;
   logic        g_flt;
   int          g_lat;
   logic        g_ackok;

   always #5 clk = ~clk;

   always @(posedge clk) cyc++;

   load_store_unit #(
      .WIDTH(32), .ADDR_WIDTH(32), .SPLIT_MISALIGNED(0)
   ) u0 (
      .clk(clk), .rst(rst),
      .req_valid(req_valid[0]), .req_ready(req_ready[0]),
      .req_we(req_we), .req_funct3(req_funct3),
      .req_addr(req_addr), .req_wdata(req_wdata),
      .rsp_valid(rsp_valid[0]), .rsp_rdata(rsp_rdata[0]),
      .rsp_fault(rsp_fault[0]),
      .mem_req(mem_req[0]), .mem_we(mem_we[0]),
      .mem_addr(mem_addr[0]), .mem_be(mem_be[0]),
      .mem_wdata(mem_wdata[0]),
      .mem_ack(mem_ack[0]), .mem_rdata(mem_rdata[0])
   );

   load_store_unit #(
      .WIDTH(32), .ADDR_WIDTH(32), .SPLIT_MISALIGNED(1)
   ) u1 (
      .clk(clk), .rst(rst),
      .req_valid(req_valid[1]), .req_ready(req_ready[1]),
      .req_we(req_we), .req_funct3(req_funct3),
      .req_addr(req_addr), .req_wdata(req_wdata),
      .rsp_valid(rsp_valid[1]), .rsp_rdata(rsp_rdata[1]),
      .rsp_fault(rsp_fault[1]),
      .mem_req(mem_req[1]), .mem_we(mem_we[1]),
      .mem_addr(mem_addr[1]), .mem_be(mem_be[1]),
      .mem_wdata(mem_wdata[1]),
      .mem_ack(mem_ack[1]), .mem_rdata(mem_rdata[1])
   );

   // memory: ack in the dly-th cycle of a request, log each beat
   always @(negedge clk) begin
      for (int i = 0; i < 2; i++) begin
         logic [31:0] w;
         mem_ack[i]   = 1'b0;
         mem_rdata[i] = 32'h0;
         if (mem_req[i]) begin
            cnt[i]++;
            if (cnt[i] >= dly) begin
               cnt[i]       = 0;
               w            = mem[mem_addr[i][9:2]];
               mem_ack[i]   = 1'b1;
               mem_rdata[i] = w;
               if (mem_we[i]) begin
                  for (int b = 0; b < 4; b++)
                     if (mem_be[i][b]) w[b*8 +: 8] = mem_wdata[i][b*8 +: 8];
                  mem[mem_addr[i][9:2]] = w;
               end
               if (nb[i] < 4) begin
                  b_addr[i][nb[i]] = mem_addr[i];
                  b_be[i][nb[i]]   = mem_be[i];
                  b_wd[i][nb[i]]   = mem_wdata[i];
               end
               nb[i]++;
               ack_edge[i] = cyc + 1;
            end
         end else begin
            cnt[i] = 0;
         end
      end
   end

   task automatic chk(input string tag, input logic [31:0] got,
                      input logic [31:0] exp);
      n_chk++;
      if (got === exp) n_pass++;
      else $display("FAIL %s: got %h expected %h", tag, got, exp);
   endtask

   task automatic setw(input logic [31:0] a, input logic [31:0] d);
      mem[a[9:2]] = d;
   endtask

   task automatic do_req(input int i, input logic we,
                         input logic [2:0] f3, input logic [31:0] a,
                         input logic [31:0] wd, input int d);
      int e_acc;
      int e_rsp;
      @(negedge clk); #1;
      dly        = d;
      nb[i]      = 0;
      req_we     = we;
      req_funct3 = f3;
      req_addr   = a;
      req_wdata  = wd;
      req_valid[i] = 1'b1;
      e_acc = cyc + 1;
      @(negedge clk); #1;
      req_valid[i] = 1'b0;
      chk("busy_not_ready", {31'b0, req_ready[i]}, 32'd0);
      g_seen = 1'b0;
      e_rsp  = 0;
      for (int t = 0; t < 64 && !g_seen; t++) begin
         if (rsp_valid[i]) begin
            g_seen = 1'b1;
            e_rsp  = cyc;
            g_rd   = rsp_rdata[i];
            g_flt  = rsp_fault[i];
         end else begin
            @(negedge clk); #1;
         end
      end
      chk("rsp_seen", {31'b0, g_seen}, 32'd1);
      g_lat   = g_seen ? e_rsp - e_acc + 1 : -1;
      g_ackok = (e_rsp == ack_edge[i]);
      @(negedge clk); #1;
      chk("rsp_pulse", {31'b0, rsp_valid[i]}, 32'd0);
   endtask

   initial begin
      logic seen;
      for (int k = 0; k < 256; k++) mem[k] = 32'h0;
      req_valid[0] = 1'b0;
      req_valid[1] = 1'b0;
      req_we       = 1'b0;
      req_funct3   = 3'b000;
      req_addr     = 32'h0;
      req_wdata    = 32'h0;
      repeat (2) @(negedge clk);
      #1;
      chk("rst_ready",  {31'b0, req_ready[0]}, 32'd1);
      chk("rst_memreq", {31'b0, mem_req[0]},   32'd0);
      chk("rst_rspv",   {31'b0, rsp_valid[1]}, 32'd0);
      chk("rst_be",     {28'b0, mem_be[1]},    32'd0);
      chk("rst_rdata",  rsp_rdata[0],          32'd0);
      rst = 1'b1;

      // aligned LW, ack after 3 cycles
      setw(32'h104, 32'hDEADBEEF);
      do_req(0, 1'b0, 3'b010, 32'h104, 32'h0, 3);
      chk("lw_nbeat", nb[0], 32'd1);
      chk("lw_addr",  b_addr[0][0], 32'h104);
      chk("lw_be",    {28'b0, b_be[0][0]}, 32'hF);
      chk("lw_data",  g_rd, 32'hDEADBEEF);
      chk("lw_fault", {31'b0, g_flt}, 32'd0);
      chk("lw_lat",   g_lat, 32'd4);
      chk("lw_after_ack", {31'b0, g_ackok}, 32'd1);

      // LB / LBU at offset 3, minimum latency
      setw(32'h100, 32'h80123456);
      do_req(0, 1'b0, 3'b000, 32'h103, 32'h0, 1);
      chk("lb_data", g_rd, 32'hFFFFFF80);
      chk("lb_lat",  g_lat, 32'd2);
      do_req(0, 1'b0, 3'b100, 32'h103, 32'h0, 1);
      chk("lbu_data", g_rd, 32'h00000080);

      // LH / LHU at offset 2
      do_req(0, 1'b0, 3'b001, 32'h102, 32'h0, 2);
      chk("lh_data", g_rd, 32'hFFFF8012);
      do_req(0, 1'b0, 3'b101, 32'h102, 32'h0, 1);
      chk("lhu_data", g_rd, 32'h00008012);

      // SH at offset 2
      setw(32'h200, 32'h11223344);
      do_req(0, 1'b1, 3'b001, 32'h202, 32'h1234ABCD, 1);
      chk("sh_addr",  b_addr[0][0], 32'h200);
      chk("sh_be",    {28'b0, b_be[0][0]}, 32'hC);
      chk("sh_wdata", b_wd[0][0], 32'hABCD0000);
      chk("sh_rdata", g_rd, 32'h0);
      chk("sh_mem",   mem[8'h80], 32'hABCD3344);

      // misaligned LW faults without a memory beat
      do_req(0, 1'b0, 3'b010, 32'h101, 32'h0, 1);
      chk("mis_fault", {31'b0, g_flt}, 32'd1);
      chk("mis_nbeat", nb[0], 32'd0);
      chk("mis_lat",   g_lat, 32'd1);
      chk("mis_rdata", g_rd, 32'h0);

      // illegal funct3 codes on a 32-bit unit
      do_req(0, 1'b0, 3'b111, 32'h100, 32'h0, 1);
      chk("f3_111_fault", {31'b0, g_flt}, 32'd1);
      do_req(1, 1'b0, 3'b011, 32'h100, 32'h0, 1);
      chk("f3_011_fault", {31'b0, g_flt}, 32'd1);
      chk("f3_011_nbeat", nb[1], 32'd0);

      // split LW across words
      setw(32'h0FC, 32'hAAAA1111);
      setw(32'h100, 32'h3333BBBB);
      do_req(1, 1'b0, 3'b010, 32'h0FE, 32'h0, 1);
      chk("slw_nbeat", nb[1], 32'd2);
      chk("slw_addr0", b_addr[1][0], 32'h0FC);
      chk("slw_be0",   {28'b0, b_be[1][0]}, 32'hC);
      chk("slw_addr1", b_addr[1][1], 32'h100);
      chk("slw_be1",   {28'b0, b_be[1][1]}, 32'h3);
      chk("slw_data",  g_rd, 32'hBBBBAAAA);
      chk("slw_fault", {31'b0, g_flt}, 32'd0);
      chk("slw_lat",   g_lat, 32'd3);

      // split SW at offset 3
      do_req(1, 1'b1, 3'b010, 32'h0FF, 32'h44332211, 2);
      chk("ssw_be0", {28'b0, b_be[1][0]}, 32'h8);
      chk("ssw_wd0", b_wd[1][0], 32'h11000000);
      chk("ssw_be1", {28'b0, b_be[1][1]}, 32'h7);
      chk("ssw_wd1", b_wd[1][1], 32'h00443322);
      chk("ssw_mem0", mem[8'h3F], 32'h11AA1111);
      chk("ssw_mem1", mem[8'h40], 32'h33443322);
      chk("ssw_lat",  g_lat, 32'd5);

      // misaligned LH inside one word: single beat
      setw(32'h100, 32'h3333BBBB);
      do_req(1, 1'b0, 3'b001, 32'h101, 32'h0, 1);
      chk("mlh_nbeat", nb[1], 32'd1);
      chk("mlh_be",    {28'b0, b_be[1][0]}, 32'h6);
      chk("mlh_data",  g_rd, 32'h000033BB);

      // split LH with sign bit coming from the second beat
      setw(32'h100, 32'h80123456);
      setw(32'h104, 32'hDEADBEEF);
      do_req(1, 1'b0, 3'b001, 32'h103, 32'h0, 1);
      chk("slh_addr1", b_addr[1][1], 32'h104);
      chk("slh_data",  g_rd, 32'hFFFFEF80);

      // reset while BEAT1 waits for ack
      @(negedge clk); #1;
      dly          = 1000;
      req_we       = 1'b0;
      req_funct3   = 3'b010;
      req_addr     = 32'h104;
      req_valid[0] = 1'b1;
      @(negedge clk); #1;
      req_valid[0] = 1'b0;
      @(negedge clk); #1;
      chk("abort_memreq_hi", {31'b0, mem_req[0]}, 32'd1);
      @(posedge clk); #2;
      rst = 1'b0;
      #1;
      chk("abort_memreq_lo", {31'b0, mem_req[0]}, 32'd0);
      chk("abort_ready",     {31'b0, req_ready[0]}, 32'd1);
      seen = 1'b0;
      repeat (2) begin
         @(negedge clk); #1;
         seen = seen | rsp_valid[0];
      end
      rst = 1'b1;
      repeat (4) begin
         @(negedge clk); #1;
         seen = seen | rsp_valid[0] | mem_req[0];
      end
      chk("abort_no_rsp", {31'b0, seen}, 32'd0);
      chk("abort_ready2", {31'b0, req_ready[0]}, 32'd1);

      // unit works again after reset
      do_req(0, 1'b0, 3'b010, 32'h104, 32'h0, 1);
      chk("post_rst_data", g_rd, 32'hDEADBEEF);

      $display("%0d/%0d checks passed", n_pass, n_chk);
      $finish;
   end

endmodule
